// File: rtl/riscv_fetch_unit_if.sv
// Bus bundle for the fetch unit: redirect input, imem request/response, decode handshake.
// master = fetch unit, slave = surrounding core/imem/testbench.
interface riscv_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: credit-limited word fetches, PC-tagged instruction FIFO,
// and redirect handling that drains stale in-flight responses.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    riscv_fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, DRAIN} state_t;
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    state_t        state, state_nx;
    logic [31:0]   fetch_pc;
    logic          req_valid;
    logic [CW-1:0] outstanding, out_nx, drop_cnt, fifo_cnt, cnt_nx;
    logic [AW-1:0] rd_ptr, wr_ptr, pq_rd, pq_wr;
    entry_t        fifo [FIFO_DEPTH];
    logic [31:0]   pcq  [FIFO_DEPTH];
    logic          accept, rsp, pop, push, redirect;
    logic [31:0]   redirect_aligned;

    assign redirect_aligned = bus.redirect_pc & ~32'h3;

    always_comb begin
        redirect = bus.redirect_valid;
        accept   = req_valid & bus.imem_req_ready;
        rsp      = bus.imem_rsp_valid;
        pop      = (fifo_cnt != '0) & bus.instr_ready;
        // a response in a redirect cycle is stale even when nothing was pending drop
        push     = rsp & (drop_cnt == '0) & ~redirect;
        out_nx   = outstanding + CW'(accept) - CW'(rsp);
        cnt_nx   = redirect ? '0 : fifo_cnt + CW'(push) - CW'(pop);
        state_nx = state;
        if (redirect)
            state_nx = (out_nx != '0) ? DRAIN : RUN;
        else if (state == DRAIN && rsp && drop_cnt == CW'(1))
            state_nx = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            req_valid   <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pq_rd       <= '0;
            pq_wr       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo[i] <= '0;
                pcq[i]  <= '0;
            end
        end else begin
            state       <= state_nx;
            outstanding <= out_nx;
            fifo_cnt    <= cnt_nx;
            // credit check on next-cycle occupancy so every in-flight response has a slot
            req_valid   <= (state_nx == RUN) &&
                           (({1'b0, out_nx} + {1'b0, cnt_nx}) < (CW+1)'(FIFO_DEPTH));
            // PC queue tracks every request, including ones later dropped, to stay aligned
            if (accept) begin
                pcq[pq_wr] <= fetch_pc;
                pq_wr      <= pq_wr + 1'b1;
            end
            if (rsp)
                pq_rd <= pq_rd + 1'b1;
            if (redirect) begin
                fetch_pc <= redirect_aligned;
                drop_cnt <= out_nx;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp && drop_cnt != '0)
                    drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    fifo[wr_ptr] <= '{data: bus.imem_rsp_data, pc: pcq[pq_rd]};
                    wr_ptr       <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.instr_valid    = (fifo_cnt != '0);
    assign bus.instr          = fifo[rd_ptr].data;
    assign bus.instr_pc       = fifo[rd_ptr].pc;
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: behavioural imem (1-cycle response when enabled),
// delivery monitor, and hand-computed expected PC/instruction sequences.
module tb_riscv_fetch_unit;
    logic clk;
    logic rst_n;
    logic rsp_en;
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   del_cnt = 0;
    logic [31:0] exp_pc;
    logic [31:0] pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_d[$];

    riscv_fetch_unit_if bus();

    riscv_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // compare every delivered instruction against the expected PC stream
    task automatic check_got(input int min_n);
        int n;
        n = 0;
        while (got_pc.size() > 0) begin
            chk("deliv_pc", got_pc.pop_front(), exp_pc);
            chk("deliv_instr", got_d.pop_front(), exp_pc ^ 32'hA5A5_0000);
            exp_pc = exp_pc + 32'd4;
            n++;
        end
        chk("deliv_count_min", 32'(n >= min_n), 32'd1);
    endtask

    task automatic drain();
        int k;
        bus.imem_req_ready = 1'b0;
        rsp_en = 1'b1;
        k = 0;
        while ((pend.size() != 0 || bus.instr_valid) && k < 30) begin
            tick();
            k++;
        end
        chk("drain_done", 32'(k < 30), 32'd1);
    endtask

    // imem model + delivery monitor, acting at the falling edge
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end else begin
                if (rsp_en && pend.size() > 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = pend.pop_front() ^ 32'hA5A5_0000;
                end else begin
                    bus.imem_rsp_valid = 1'b0;
                    bus.imem_rsp_data  = '0;
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    pend.push_back(bus.imem_req_addr);
                    acc_cnt++;
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    got_pc.push_back(bus.instr_pc);
                    got_d.push_back(bus.instr);
                    del_cnt++;
                end
            end
        end
    end

    initial begin
        int k, gaps, a0;
        rst_n = 1'b0;
        rsp_en = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b0;
        exp_pc = 32'h0;

        // reset
        tick();
        tick();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, 32'h0);
        chk("first_instr_valid", 32'(bus.instr_valid), 32'd0);

        // stream
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        rsp_en = 1'b1;
        k = 0;
        while (!bus.instr_valid && k < 10) begin
            tick();
            k++;
        end
        chk("stream_start", 32'(k < 10), 32'd1);
        gaps = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!bus.instr_valid) gaps++;
        end
        chk("stream_gaps", 32'(gaps), 32'd0);
        check_got(12);

        // backpressure
        bus.instr_ready = 1'b0;
        repeat (10) tick();
        check_got(0);
        chk("bp_buffered", 32'(acc_cnt - del_cnt), 32'd4);
        chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("bp_instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("bp_head_pc", bus.instr_pc, exp_pc);
        bus.instr_ready = 1'b1;
        repeat (14) tick();
        check_got(14);

        // redirect with two requests in flight
        drain();
        check_got(0);
        rsp_en = 1'b0;
        a0 = acc_cnt;
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        bus.imem_req_ready = 1'b0;
        chk("inflight_two", 32'(acc_cnt - a0), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        tick();
        bus.redirect_valid = 1'b0;
        chk("drain_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("drain_instr_valid", 32'(bus.instr_valid), 32'd0);
        exp_pc = 32'h100;
        bus.imem_req_ready = 1'b1;
        rsp_en = 1'b1;
        tick();
        chk("drain_still", 32'(bus.imem_req_valid), 32'd0);
        repeat (12) tick();
        check_got(8);

        // redirect + response + head pop in the same cycle
        repeat (4) tick();
        check_got(0);
        chk("sim_head_valid", 32'(bus.instr_valid), 32'd1);
        chk("sim_head_pc", bus.instr_pc, exp_pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_valid = 1'b0;
        chk("sim_popped_once", 32'(got_pc.size()), 32'd1);
        check_got(1);
        chk("sim_drain_req", 32'(bus.imem_req_valid), 32'd0);
        chk("sim_flushed", 32'(bus.instr_valid), 32'd0);
        exp_pc = 32'h200;
        repeat (12) tick();
        check_got(8);

        // wrap with request stall
        drain();
        check_got(0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("stall_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
            tick();
        end
        exp_pc = 32'hFFFF_FFFC;
        bus.imem_req_ready = 1'b1;
        repeat (8) tick();
        check_got(3);

        // reset in the middle of streaming
        rst_n = 1'b0;
        tick();
        chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("mid_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("mid_rst_addr", bus.imem_req_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
